ahb_slave_mem: RTL and testbench
================================

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter DEPTH, default 64, SHALL set the memory size in 32-bit words (power of two, 4..1024).
REQ-002 Parameter WAIT, default 1, SHALL set the number of wait cycles inserted into every OKAY data phase (0..7).
REQ-003 hclk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 hrest  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 hsel  in  1  SHALL be the slave select.
REQ-006 htrans  in  2  SHALL be the transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-007 hwrite  in  1  SHALL select write (1) or read (0).
REQ-008 haddr  in  32  SHALL be the byte address.
REQ-009 hsize  in  2  SHALL be the transfer size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-010 hburst  in  3  and  hprot  in  4  SHALL be accepted and ignored.
REQ-011 hwdata  in  32  SHALL be the write data, sampled in the data phase.
REQ-012 hready_in  in  1  SHALL be the bus-level HREADY.
REQ-013 hready_out  out  1  SHALL be the slave ready.
REQ-014 hresp  out  2  SHALL be the response: 00 OKAY, 01 ERROR.
REQ-015 hrdata  out  32  SHALL be the read data.

Function
REQ-016 An address phase SHALL be accepted when hsel=1, htrans[1]=1 and hready_in=1 in the same cycle; haddr, hwrite and hsize SHALL be registered at that edge.
REQ-017 IDLE, BUSY or unselected cycles SHALL produce a zero-wait OKAY response (hready_out=1, hresp=00) and SHALL NOT access memory.
REQ-018 FSM states SHALL be IDLE, WAITST, LAST, ERR1 and ERR2.
REQ-019 Transitions on an accepted OKAY transfer SHALL be: IDLE -> WAITST when WAIT>0, otherwise IDLE -> LAST; WAITST -> LAST after WAIT cycles.
REQ-020 LAST SHALL go to WAITST, LAST or ERR1 when a new transfer is accepted in that cycle (pipelined), otherwise to IDLE.
REQ-021 hready_out SHALL be 0 in WAITST and ERR1, and 1 in IDLE, LAST and ERR2.
REQ-022 A transfer SHALL be an error when any of the following holds: haddr[31:2] >= DEPTH; hsize=11; hsize=01 with haddr[0]=1; hsize=10 with haddr[1:0]!=00.
REQ-023 An error transfer SHALL enter ERR1 (hresp=01, hready_out=0) and then ERR2 (hresp=01, hready_out=1), with no wait states and no memory write.
REQ-024 A transfer accepted during ERR2 SHALL be ignored, so that the master's cancellation to IDLE is honoured.
REQ-025 A write SHALL update memory at the edge ending LAST, using hwdata byte lanes selected by hsize and haddr[1:0] (little-endian); unselected bytes SHALL be unchanged.
REQ-026 In LAST, a read SHALL drive hrdata with the full addressed word, read combinationally from the array.
REQ-027 A read whose data phase immediately follows a write to the same word SHALL return the newly written data.
REQ-028 In all other states hrdata SHALL be 0.
REQ-029 hresp SHALL be 00 in all states except ERR1 and ERR2.

Reset
REQ-030 While hrest=1: state=IDLE, hready_out=1, hresp=00, hrdata=0, and all memory words SHALL be 0.
REQ-031 Assertion of hrest in mid-transfer SHALL abort the transfer with no memory write; operation SHALL resume on the first edge after deassertion.

Verification
REQ-032 WAIT=1: word write of 0xDEADBEEF to 0x10, then read of 0x10 -> each data phase has 1 cycle with hready_out=0, then hready_out=1; read returns 0xDEADBEEF with hresp=00.
REQ-033 Byte write of 0xXXXXAAXX to 0x11 over word 0x11223344 -> read of 0x10 returns 0x1122AA44.
REQ-034 WAIT=0: back-to-back pipelined write 0x5 to 0x0 then read 0x0 -> zero waits; read returns 0x00000005.
REQ-035 Read of 0x100 with DEPTH=64, and word read of 0x2 -> each gives ERR1 (hresp=01, hready_out=0) then ERR2 (hresp=01, hready_out=1); memory is unchanged.
REQ-036 hrest pulsed during the WAITST of a write to 0x4 -> a subsequent read of 0x4 returns 0x00000000; hready_out=1 during reset.
REQ-037 htrans=BUSY with hsel=1, and NONSEQ with hsel=0 -> hready_out=1, hresp=00, no memory change.

Source files
------------

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master/interconnect and ahb_slave_mem.
// Carries the address phase, the write data and the slave response.
interface ahb_slave_mem_if;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [1:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, htrans, hwrite, haddr, hsize, hburst, hprot, hwdata, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, hwrite, haddr, hsize, hburst, hprot, hwdata, hready_in,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a DEPTH x 32-bit register array with WAIT wait states per OKAY data phase.
// Misaligned, oversized or out-of-range transfers get a two-cycle ERROR response and never touch the array.
module ahb_slave_mem #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 1
) (
  input  logic           hclk,
  input  logic           hrest,
  ahb_slave_mem_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [2:0] WAIT_LOAD = 3'((WAIT > 0) ? (WAIT - 1) : 0);

  typedef enum logic [2:0] {
    IDLE,
    WAITST,
    LAST,
    ERR1,
    ERR2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [AW-1:0] word_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic          write_q;
  logic [2:0]    wait_cnt;
  logic [3:0]    byte_en;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          take;
  logic          addr_err;
  logic          unused_ok;

  assign unused_ok = ^{bus.hburst, bus.hprot};

  assign accept = bus.hsel && bus.htrans[1] && bus.hready_in;
  // Only IDLE and LAST open a new data phase; ERR2 drops the offer so the master can cancel to IDLE.
  assign take   = accept && ((state == IDLE) || (state == LAST));

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    addr_err = 1'b0;
    if (bus.haddr[31:2] >= 30'(DEPTH)) addr_err = 1'b1;
    case (bus.hsize)
      2'b01:   if (bus.haddr[0]) addr_err = 1'b1;
      2'b10:   if (bus.haddr[1:0] != 2'b00) addr_err = 1'b1;
      2'b11:   addr_err = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      2'b00:   byte_en = 4'b0001 << lane_q;
      2'b01:   byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk or posedge hrest) begin
    if (hrest) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.hready_out = 1'b1;
    bus.hresp      = 2'b00;
    bus.hrdata     = '0;
    case (state)
      IDLE, LAST: begin
        if (take) begin
          if (addr_err)      state_nxt = ERR1;
          else if (WAIT > 0) state_nxt = WAITST;
          else               state_nxt = LAST;
        end else begin
          state_nxt = IDLE;
        end
        if ((state == LAST) && !write_q) bus.hrdata = mem[word_q];
      end
      WAITST: begin
        bus.hready_out = 1'b0;
        if (wait_cnt == 3'd0) state_nxt = LAST;
      end
      ERR1: begin
        bus.hready_out = 1'b0;
        bus.hresp      = 2'b01;
        state_nxt      = ERR2;
      end
      ERR2: begin
        bus.hresp = 2'b01;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hrest) begin
    if (hrest) begin
      word_q   <= '0;
      lane_q   <= 2'b00;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
      wait_cnt <= 3'd0;
    end else if (take) begin
      word_q   <= bus.haddr[AW+1:2];
      lane_q   <= bus.haddr[1:0];
      size_q   <= bus.hsize;
      write_q  <= bus.hwrite;
      wait_cnt <= WAIT_LOAD;
    end else if ((state == WAITST) && (wait_cnt != 3'd0)) begin
      wait_cnt <= wait_cnt - 3'd1;
    end
  end

  // NOTE: the array is reset asynchronously because every word must read zero after hrest;
  // this keeps it in flops rather than a RAM macro.
  always_ff @(posedge hclk or posedge hrest) begin
    if (hrest) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if ((state == LAST) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one WAIT=1 instance and one WAIT=0 instance on separate buses.
module tb_ahb_slave_mem;

  logic hclk = 1'b0;
  logic hrest;
  always #5 hclk = ~hclk;

  ahb_slave_mem_if b0 ();
  ahb_slave_mem_if b1 ();

  // Single-slave buses: the bus-level HREADY is the slave's own ready.
  assign b0.hready_in = b0.hready_out;
  assign b1.hready_in = b1.hready_out;

  ahb_slave_mem #(.DEPTH(64), .WAIT(1)) dut0 (.hclk(hclk), .hrest(hrest), .bus(b0));
  ahb_slave_mem #(.DEPTH(64), .WAIT(0)) dut1 (.hclk(hclk), .hrest(hrest), .bus(b1));

  int n_vec = 0;
  int n_bad = 0;

  task automatic idle_all();
    b0.hsel = 1'b0; b0.htrans = 2'b00; b0.hwrite = 1'b0; b0.haddr = '0;
    b0.hsize = 2'b10; b0.hburst = 3'b001; b0.hprot = 4'b0011; b0.hwdata = '0;
    b1.hsel = 1'b0; b1.htrans = 2'b00; b1.hwrite = 1'b0; b1.haddr = '0;
    b1.hsize = 2'b10; b1.hburst = 3'b001; b1.hprot = 4'b0011; b1.hwdata = '0;
  endtask

  // One non-pipelined transfer on b0; entered and left at posedge+1.
  task automatic xfer0(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, output int waits,
                       output logic [1:0] resp_first, output logic [1:0] resp_last,
                       output logic [31:0] rdata);
    b0.hsel = 1'b1; b0.htrans = 2'b10; b0.hwrite = wr; b0.haddr = addr; b0.hsize = size;
    @(posedge hclk); #1;
    b0.hsel = 1'b0; b0.htrans = 2'b00; b0.hwdata = wdata;
    waits = 0;
    @(negedge hclk);
    resp_first = b0.hresp;
    while (!b0.hready_out && waits < 16) begin
      waits++;
      @(negedge hclk);
    end
    resp_last = b0.hresp;
    rdata     = b0.hrdata;
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    hrest = 1'b1;
    idle_all();
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    n_vec++; if (b0.hready_out !== 1'b1) begin n_bad++; $display("FAIL rst.ready0 got %b want 1", b0.hready_out); end
    n_vec++; if (b0.hresp !== 2'b00) begin n_bad++; $display("FAIL rst.resp0 got %b want 00", b0.hresp); end
    n_vec++; if (b0.hrdata !== 32'h0) begin n_bad++; $display("FAIL rst.rdata0 got %h want 0", b0.hrdata); end
    n_vec++; if (b1.hready_out !== 1'b1) begin n_bad++; $display("FAIL rst.ready1 got %b want 1", b1.hready_out); end
    hrest = 1'b0;
    @(posedge hclk); #1;
  endtask

  task automatic test_word();
    int w; logic [1:0] rf, rl; logic [31:0] rd;
    xfer0(1'b1, 32'h10, 2'b10, 32'hDEADBEEF, w, rf, rl, rd);
    n_vec++; if (w !== 1) begin n_bad++; $display("FAIL word_wr.waits got %0d want 1", w); end
    n_vec++; if (rl !== 2'b00) begin n_bad++; $display("FAIL word_wr.resp got %b want 00", rl); end
    xfer0(1'b0, 32'h10, 2'b10, 32'h0, w, rf, rl, rd);
    n_vec++; if (w !== 1) begin n_bad++; $display("FAIL word_rd.waits got %0d want 1", w); end
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_rd.data got %h want deadbeef", rd); end
    n_vec++; if (rf !== 2'b00 || rl !== 2'b00) begin n_bad++; $display("FAIL word_rd.resp got %b/%b want 00/00", rf, rl); end
  endtask

  task automatic test_byte_lanes();
    int w; logic [1:0] rf, rl; logic [31:0] rd;
    xfer0(1'b1, 32'h10, 2'b10, 32'h11223344, w, rf, rl, rd);
    xfer0(1'b1, 32'h11, 2'b00, 32'h5566AA77, w, rf, rl, rd);
    xfer0(1'b0, 32'h10, 2'b10, 32'h0, w, rf, rl, rd);
    n_vec++; if (rd !== 32'h1122AA44) begin n_bad++; $display("FAIL byte_wr.data got %h want 1122aa44", rd); end
    xfer0(1'b1, 32'h12, 2'b01, 32'hBEEF1234, w, rf, rl, rd);
    xfer0(1'b0, 32'h10, 2'b10, 32'h0, w, rf, rl, rd);
    n_vec++; if (rd !== 32'hBEEFAA44) begin n_bad++; $display("FAIL half_wr.data got %h want beefaa44", rd); end
    xfer0(1'b1, 32'hFC, 2'b10, 32'hCAFEF00D, w, rf, rl, rd);
    xfer0(1'b0, 32'hFC, 2'b10, 32'h0, w, rf, rl, rd);
    n_vec++; if (rd !== 32'hCAFEF00D || rl !== 2'b00) begin n_bad++; $display("FAIL top_word got %h/%b want cafef00d/00", rd, rl); end
  endtask

  task automatic test_errors();
    int w; logic [1:0] rf, rl; logic [31:0] rd;
    logic [31:0] err_addr [5] = '{32'h100, 32'h2, 32'h12, 32'h10, 32'h11};
    logic [1:0]  err_size [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
    logic        err_wr   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      xfer0(err_wr[i], err_addr[i], err_size[i], 32'hFFFFFFFF, w, rf, rl, rd);
      n_vec++;
      if (w !== 1 || rf !== 2'b01 || rl !== 2'b01)
        begin n_bad++; $display("FAIL err[%0d] waits/resp got %0d/%b/%b want 1/01/01", i, w, rf, rl); end
    end
    xfer0(1'b0, 32'h10, 2'b10, 32'h0, w, rf, rl, rd);
    n_vec++; if (rd !== 32'hBEEFAA44) begin n_bad++; $display("FAIL err.mem_kept got %h want beefaa44", rd); end

    // A write offered through ERR1/ERR2 must be dropped.
    b0.hsel = 1'b1; b0.htrans = 2'b10; b0.hwrite = 1'b0; b0.haddr = 32'h2; b0.hsize = 2'b10;
    @(posedge hclk); #1;
    b0.hwrite = 1'b1; b0.haddr = 32'h10;
    @(negedge hclk);
    n_vec++; if (b0.hready_out !== 1'b0 || b0.hresp !== 2'b01) begin n_bad++; $display("FAIL err1 got %b/%b want 0/01", b0.hready_out, b0.hresp); end
    @(posedge hclk); #1;
    @(negedge hclk);
    n_vec++; if (b0.hready_out !== 1'b1 || b0.hresp !== 2'b01) begin n_bad++; $display("FAIL err2 got %b/%b want 1/01", b0.hready_out, b0.hresp); end
    @(posedge hclk); #1;
    b0.hsel = 1'b0; b0.htrans = 2'b00; b0.hwdata = 32'hFFFFFFFF;
    @(negedge hclk);
    n_vec++; if (b0.hready_out !== 1'b1 || b0.hresp !== 2'b00) begin n_bad++; $display("FAIL err2_drop got %b/%b want 1/00", b0.hready_out, b0.hresp); end
    @(posedge hclk); #1;
    xfer0(1'b0, 32'h10, 2'b10, 32'h0, w, rf, rl, rd);
    n_vec++; if (rd !== 32'hBEEFAA44) begin n_bad++; $display("FAIL err2_drop.mem got %h want beefaa44", rd); end
  endtask

  task automatic test_idle_busy();
    int w; logic [1:0] rf, rl; logic [31:0] rd;
    b0.hsel = 1'b1; b0.htrans = 2'b01; b0.hwrite = 1'b1; b0.haddr = 32'h10; b0.hsize = 2'b10; b0.hwdata = 32'h0;
    repeat (2) begin
      @(negedge hclk);
      n_vec++; if (b0.hready_out !== 1'b1 || b0.hresp !== 2'b00) begin n_bad++; $display("FAIL busy got %b/%b want 1/00", b0.hready_out, b0.hresp); end
    end
    @(posedge hclk); #1;
    b0.hsel = 1'b0; b0.htrans = 2'b10;
    repeat (2) begin
      @(negedge hclk);
      n_vec++; if (b0.hready_out !== 1'b1 || b0.hresp !== 2'b00) begin n_bad++; $display("FAIL unsel got %b/%b want 1/00", b0.hready_out, b0.hresp); end
    end
    @(posedge hclk); #1;
    idle_all();
    xfer0(1'b0, 32'h10, 2'b10, 32'h0, w, rf, rl, rd);
    n_vec++; if (rd !== 32'hBEEFAA44) begin n_bad++; $display("FAIL busy.mem_kept got %h want beefaa44", rd); end
  endtask

  task automatic test_back_to_back();
    b1.hsel = 1'b1; b1.htrans = 2'b10; b1.hwrite = 1'b1; b1.haddr = 32'h0; b1.hsize = 2'b10;
    @(posedge hclk); #1;
    b1.hwrite = 1'b0; b1.hwdata = 32'h5;
    @(negedge hclk);
    n_vec++; if (b1.hready_out !== 1'b1) begin n_bad++; $display("FAIL b2b.wr_ready got %b want 1", b1.hready_out); end
    @(posedge hclk); #1;
    b1.hsel = 1'b0; b1.htrans = 2'b00; b1.hwdata = 32'h0;
    @(negedge hclk);
    n_vec++; if (b1.hready_out !== 1'b1) begin n_bad++; $display("FAIL b2b.rd_ready got %b want 1", b1.hready_out); end
    n_vec++; if (b1.hrdata !== 32'h5 || b1.hresp !== 2'b00) begin n_bad++; $display("FAIL b2b.rd got %h/%b want 00000005/00", b1.hrdata, b1.hresp); end
    @(posedge hclk); #1;
  endtask

  task automatic test_reset_mid();
    int w; logic [1:0] rf, rl; logic [31:0] rd;
    b0.hsel = 1'b1; b0.htrans = 2'b10; b0.hwrite = 1'b1; b0.haddr = 32'h4; b0.hsize = 2'b10;
    @(posedge hclk); #1;
    b0.hsel = 1'b0; b0.htrans = 2'b00; b0.hwdata = 32'h12345678;
    @(negedge hclk);
    n_vec++; if (b0.hready_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid.waitst got %b want 0", b0.hready_out); end
    hrest = 1'b1;
    #1;
    n_vec++; if (b0.hready_out !== 1'b1 || b0.hresp !== 2'b00) begin n_bad++; $display("FAIL rst_mid.ready got %b/%b want 1/00", b0.hready_out, b0.hresp); end
    @(negedge hclk);
    hrest = 1'b0;
    @(posedge hclk); #1;
    xfer0(1'b0, 32'h4, 2'b10, 32'h0, w, rf, rl, rd);
    n_vec++; if (rd !== 32'h0 || w !== 1) begin n_bad++; $display("FAIL rst_mid.rd4 got %h/%0d want 00000000/1", rd, w); end
    xfer0(1'b0, 32'h10, 2'b10, 32'h0, w, rf, rl, rd);
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_mid.clear got %h want 00000000", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_errors();
    test_idle_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
